cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: evicts a victim cache line and refills it from memory.
// A request captures the victim set and the missing line address. Dirty
// victims are first written back one word at a time: array read, then memory
// write. The new line is then fetched one beat at a time, and each returned
// beat is written straight into the array.
// Optional feature macro: CACHE_REFILL_WRITEBACK_EN builds the write-back
// path. Without it, every request is a fetch-only refill.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for victim_valid_i
// WB_READ    | read one victim word from the array (write-back builds only)
// WB_WRITE   | memory write of that word, held until granted (write-back)
// FETCH_REQ  | memory read request for one beat of the missing line
// FETCH_WAIT | waiting for the read beat, then writing it into the array
// DONE       | one-cycle completion pulse
module cache_refill_ctrl #(
    parameter int WORD_WID   = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 10,
    parameter int ADDR_W     = 32,
    localparam int CNT_W     = $clog2(LINE_WORDS),
    localparam int BYTE_W    = $clog2(WORD_WID / 8),
    localparam int TAG_W     = ADDR_W - IDX_W - CNT_W - BYTE_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                victim_valid_i,
    input  logic [IDX_W-1:0]    victim_idx_i,
    input  logic [TAG_W-1:0]    victim_tag_i,
    input  logic                victim_dirty_i,
    input  logic [ADDR_W-1:0]   miss_addr_i,

    output logic [IDX_W-1:0]    arr_idx_o,
    output logic [CNT_W-1:0]    arr_word_o,
    output logic                arr_rd_en_o,
    input  logic [WORD_WID-1:0] arr_rd_data_i,
    output logic                arr_wr_en_o,
    output logic [WORD_WID-1:0] arr_wr_data_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [WORD_WID-1:0] mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [WORD_WID-1:0] mem_rdata_i,

    output logic                busy_o,
    output logic                done_o
);

    localparam int LINE_W = ADDR_W - CNT_W - BYTE_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
`ifdef CACHE_REFILL_WRITEBACK_EN
        WB_READ    = 3'd1,
        WB_WRITE   = 3'd2,
`endif
        FETCH_REQ  = 3'd3,
        FETCH_WAIT = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  line_q, line_d;

    // The byte/word offset of the miss address is discarded: the whole line is fetched.
    logic [CNT_W+BYTE_W-1:0] unused_miss_lo;
    assign unused_miss_lo = miss_addr_i[CNT_W+BYTE_W-1:0];

`ifdef CACHE_REFILL_WRITEBACK_EN
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [WORD_WID-1:0] wdata_q, wdata_d;
    // Set for the first WB_WRITE cycle, when arr_rd_data_i carries the word just read.
    logic                rd_pend_q, rd_pend_d;
    logic [WORD_WID-1:0] wdata_cur;
`else
    logic                unused_dirty;
    logic [TAG_W-1:0]    unused_tag;
    logic [WORD_WID-1:0] unused_rd_data;
    assign unused_dirty   = victim_dirty_i;
    assign unused_tag     = victim_tag_i;
    assign unused_rd_data = arr_rd_data_i;
`endif

    // State and captured-request registers; reset clears everything mid-burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            line_q    <= '0;
`ifdef CACHE_REFILL_WRITEBACK_EN
            tag_q     <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
`ifdef CACHE_REFILL_WRITEBACK_EN
            tag_q     <= tag_d;
            wdata_q   <= wdata_d;
            rd_pend_q <= rd_pend_d;
`endif
        end
    end

    // Next-state and output decode; outputs are zero unless a state drives them.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        line_d        = line_q;
`ifdef CACHE_REFILL_WRITEBACK_EN
        tag_d         = tag_q;
        wdata_d       = wdata_q;
        rd_pend_d     = 1'b0;
        wdata_cur     = wdata_q;
`endif
        arr_idx_o     = '0;
        arr_word_o    = '0;
        arr_rd_en_o   = 1'b0;
        arr_wr_en_o   = 1'b0;
        arr_wr_data_o = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        done_o        = 1'b0;
        busy_o        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (victim_valid_i) begin
                    idx_d  = victim_idx_i;
                    line_d = miss_addr_i[ADDR_W-1 -: LINE_W];
                    cnt_d  = '0;
`ifdef CACHE_REFILL_WRITEBACK_EN
                    tag_d   = victim_tag_i;
                    state_d = victim_dirty_i ? WB_READ : FETCH_REQ;
`else
                    state_d = FETCH_REQ;
`endif
                end
            end

`ifdef CACHE_REFILL_WRITEBACK_EN
            WB_READ: begin
                arr_rd_en_o = 1'b1;
                arr_idx_o   = idx_q;
                arr_word_o  = cnt_q;
                rd_pend_d   = 1'b1;
                state_d     = WB_WRITE;
            end

            WB_WRITE: begin
                // Forward read data on the first cycle, then hold the captured copy.
                wdata_cur   = rd_pend_q ? arr_rd_data_i : wdata_q;
                wdata_d     = wdata_cur;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q, idx_q, cnt_q, {BYTE_W{1'b0}}};
                mem_wdata_o = wdata_cur;
                if (mem_gnt_i) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_q == LAST_WORD) ? FETCH_REQ : WB_READ;
                end
            end
`endif

            FETCH_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {line_q, cnt_q, {BYTE_W{1'b0}}};
                if (mem_gnt_i) begin
                    state_d = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                if (mem_rvalid_i) begin
                    arr_wr_en_o   = 1'b1;
                    arr_wr_data_o = mem_rdata_i;
                    arr_idx_o     = idx_q;
                    arr_word_o    = cnt_q;
                    cnt_d         = cnt_q + CNT_ONE;
                    state_d       = (cnt_q == LAST_WORD) ? DONE : FETCH_REQ;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: memory/array responders plus a scoreboard of
// expected memory transactions and array writes, pushed when a request is issued.
module tb_cache_refill_ctrl;

    localparam int TAG_W = 17;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        victim_valid_i;
    logic [9:0]  victim_idx_i;
    logic [TAG_W-1:0] victim_tag_i;
    logic        victim_dirty_i;
    logic [31:0] miss_addr_i;
    logic [9:0]  arr_idx_o;
    logic [1:0]  arr_word_o;
    logic        arr_rd_en_o;
    logic [63:0] arr_rd_data_i;
    logic        arr_wr_en_o;
    logic [63:0] arr_wr_data_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    cache_refill_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .victim_valid_i(victim_valid_i), .victim_idx_i(victim_idx_i),
        .victim_tag_i(victim_tag_i), .victim_dirty_i(victim_dirty_i),
        .miss_addr_i(miss_addr_i),
        .arr_idx_o(arr_idx_o), .arr_word_o(arr_word_o), .arr_rd_en_o(arr_rd_en_o),
        .arr_rd_data_i(arr_rd_data_i), .arr_wr_en_o(arr_wr_en_o),
        .arr_wr_data_o(arr_wr_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .done_o(done_o)
    );

`ifdef CACHE_REFILL_WRITEBACK_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] data;
    } mem_exp_t;

    typedef struct {
        logic [9:0]  idx;
        logic [1:0]  word;
        logic [63:0] data;
    } arr_exp_t;

    mem_exp_t exp_mem[$];
    arr_exp_t exp_arr[$];

    int checks = 0;
    int errors = 0;

    int done_cnt = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    int rd_gnt_cnt = 0;

    bit          rd_pending = 0;
    logic [31:0] rd_addr = '0;
    bit          resp_hold = 0;

    bit          stall_armed = 0;
    bit          stall_we = 0;
    int          stall_left = 0;
    logic [31:0] stall_addr = '0;
    logic [63:0] stall_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {32'hA5A5_0000 ^ a, ~a};
    endfunction

    function automatic logic [63:0] arr_data(input logic [9:0] idx, input logic [1:0] w);
        return 64'hC0DE_0000_0000_0000 | (64'(idx) << 8) | 64'(w);
    endfunction

    // Array read port model: data appears one cycle after the read enable, junk otherwise.
    initial begin
        bit         rd_prev;
        logic [9:0] p_idx;
        logic [1:0] p_word;
        rd_prev = 0;
        p_idx = '0;
        p_word = '0;
        arr_rd_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            arr_rd_data_i = rd_prev ? arr_data(p_idx, p_word) : 64'hDEAD_BEEF_DEAD_BEEF;
            rd_prev = arr_rd_en_o;
            p_idx   = arr_idx_o;
            p_word  = arr_word_o;
        end
    end

    // Memory responder and output monitor.
    initial begin
        bit gnt;
        mem_gnt_i = 0;
        mem_rvalid_i = 0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (rd_pending && !resp_hold) begin
                mem_rvalid_i = 1;
                mem_rdata_i  = mem_data(rd_addr);
                rd_pending   = 0;
            end else begin
                mem_rvalid_i = 0;
                mem_rdata_i  = 64'h0BAD_0BAD_0BAD_0BAD;
            end
            gnt = 0;
            if (mem_req_o) begin
                if (stall_armed && mem_addr_o[4:3] == 2'd2 && mem_we_o == stall_we) begin
                    if (stall_left == 5) begin
                        stall_addr  = mem_addr_o;
                        stall_wdata = mem_wdata_o;
                    end else begin
                        chk("bp_addr", mem_addr_o, stall_addr);
                        chk("bp_wdata", mem_wdata_o, stall_wdata);
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        gnt = 1;
                        stall_armed = 0;
                    end
                end else begin
                    gnt = 1;
                end
            end
            mem_gnt_i = gnt;
            #1;
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (!busy_o || done_o)
                chk("quiet", {61'd0, mem_req_o, arr_rd_en_o, arr_wr_en_o}, 64'd0);
            if (!WB_ON && mem_req_o)
                chk("we_off", {63'd0, mem_we_o}, 64'd0);
            if (mem_req_o && mem_gnt_i) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_extra", {63'd0, mem_req_o}, 64'd0);
                end else begin
                    mem_exp_t e;
                    e = exp_mem.pop_front();
                    chk("mem_we", {63'd0, mem_we_o}, {63'd0, e.we});
                    chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, e.addr});
                    if (e.we) chk("mem_wdata", mem_wdata_o, e.data);
                end
                if (!mem_we_o) begin
                    rd_pending = 1;
                    rd_addr    = mem_addr_o;
                    rd_gnt_cnt++;
                end
            end
            if (arr_wr_en_o) begin
                wr_cnt++;
                if (exp_arr.size() == 0) begin
                    chk("arr_extra", {63'd0, arr_wr_en_o}, 64'd0);
                end else begin
                    arr_exp_t a;
                    a = exp_arr.pop_front();
                    chk("arr_idx", {54'd0, arr_idx_o}, {54'd0, a.idx});
                    chk("arr_word", {62'd0, arr_word_o}, {62'd0, a.word});
                    chk("arr_data", arr_wr_data_o, a.data);
                end
            end
        end
    end

    task automatic request(input logic [9:0] idx, input logic [TAG_W-1:0] tag,
                           input bit dirty, input logic [31:0] miss);
        logic [31:0] a;
        @(negedge clk_i);
        #2;
        victim_valid_i = 1;
        victim_idx_i   = idx;
        victim_tag_i   = tag;
        victim_dirty_i = dirty;
        miss_addr_i    = miss;
        if (WB_ON && dirty) begin
            for (int w = 0; w < 4; w++) begin
                a = (32'(tag) << 15) | (32'(idx) << 5) | (32'(w) << 3);
                exp_mem.push_back('{we: 1'b1, addr: a, data: arr_data(idx, 2'(w))});
            end
        end
        for (int w = 0; w < 4; w++) begin
            a = (miss & 32'hFFFF_FFE0) | (32'(w) << 3);
            exp_mem.push_back('{we: 1'b0, addr: a, data: 64'd0});
            exp_arr.push_back('{idx: idx, word: 2'(w), data: mem_data(a)});
        end
        @(negedge clk_i);
        #2;
        victim_valid_i = 0;
    endtask

    task automatic finish_req(input string tag, input int d0, input int b0, input int exp_busy);
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            @(negedge clk_i);
            #2;
        end
        @(negedge clk_i);
        #2;
        chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_busy"}, 64'(busy_cnt - b0), 64'(exp_busy));
        chk({tag, "_memq"}, 64'(exp_mem.size()), 64'd0);
        chk({tag, "_arrq"}, 64'(exp_arr.size()), 64'd0);
        chk({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        int d0;
        int b0;
        int g0;
        int w0;
        rst_ni = 0;
        victim_valid_i = 0;
        victim_idx_i = '0;
        victim_tag_i = '0;
        victim_dirty_i = 0;
        miss_addr_i = '0;
        #1;
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ctl", {58'd0, mem_req_o, mem_we_o, arr_rd_en_o, arr_wr_en_o, done_o, 1'b0}, 64'd0);
        chk("rst_addr", {22'd0, mem_addr_o, arr_idx_o}, 64'd0);
        chk("rst_data", mem_wdata_o | arr_wr_data_o, 64'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1;

        // Clean refill
        d0 = done_cnt; b0 = busy_cnt;
        request(10'h005, 17'h1AB, 1'b0, 32'h0001_2345);
        finish_req("clean", d0, b0, 9);

        // Dirty victim
        d0 = done_cnt; b0 = busy_cnt;
        request(10'h3FF, 17'h00001, 1'b1, 32'h0000_8008);
        finish_req("dirty", d0, b0, WB_ON ? 17 : 9);

        // Grant held low for five cycles on word 2
        stall_we = WB_ON;
        stall_left = 5;
        stall_armed = 1;
        d0 = done_cnt; b0 = busy_cnt;
        request(10'h0A2, 17'h1F0F0, 1'b1, 32'hFEDC_BA98);
        finish_req("bp", d0, b0, WB_ON ? 22 : 14);
        chk("bp_used", {63'd0, stall_armed}, 64'd0);

        // Stray request during FETCH_WAIT
        d0 = done_cnt; b0 = busy_cnt; g0 = rd_gnt_cnt;
        request(10'h011, 17'h00022, 1'b0, 32'h0040_0000);
        for (int i = 0; i < 50 && rd_gnt_cnt == g0; i++) begin
            @(negedge clk_i);
            #2;
        end
        @(posedge clk_i);
        #1;
        victim_valid_i = 1;
        victim_idx_i   = 10'h3C3;
        miss_addr_i    = 32'h7777_7000;
        @(posedge clk_i);
        #1;
        victim_valid_i = 0;
        finish_req("stray", d0, b0, 9);
        repeat (2) @(negedge clk_i);
        #2;
        chk("stray_idle", {63'd0, busy_o}, 64'd0);

        // Reset while fetching word 2
        w0 = wr_cnt; g0 = rd_gnt_cnt;
        request(10'h155, 17'h00000, 1'b0, 32'h1234_5660);
        for (int i = 0; i < 50 && wr_cnt < w0 + 2; i++) begin
            @(negedge clk_i);
            #2;
        end
        resp_hold = 1;
        for (int i = 0; i < 50 && rd_gnt_cnt < g0 + 3; i++) begin
            @(negedge clk_i);
            #2;
        end
        chk("rst_mid_gnt", 64'(rd_gnt_cnt - g0), 64'd3);
        @(posedge clk_i);
        #2;
        chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        rst_ni = 0;
        #1;
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("mid_rst_ctl", {59'd0, mem_req_o, mem_we_o, arr_rd_en_o, arr_wr_en_o, done_o}, 64'd0);
        chk("mid_rst_bus", {22'd0, mem_addr_o, arr_idx_o} | arr_wr_data_o | mem_wdata_o, 64'd0);
        exp_mem.delete();
        exp_arr.delete();
        @(posedge clk_i);
        #2;
        rst_ni = 1;
        resp_hold = 0;
        @(negedge clk_i);
        #2;
        chk("late_rvalid", {63'd0, mem_rvalid_i}, 64'd1);
        chk("late_wr", {63'd0, arr_wr_en_o}, 64'd0);
        chk("late_busy", {63'd0, busy_o}, 64'd0);
        d0 = done_cnt; b0 = busy_cnt;
        request(10'h155, 17'h00000, 1'b0, 32'h1234_5660);
        finish_req("post_rst", d0, b0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
